// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low pattern table (seg[6:0] = g..a),
// a {valid, nibble} decode helper and the scan-decoder FSM state type.
package seg7_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Returns {1'b1, nibble} on a table hit, 5'b0 for any other pattern.
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_decode.sv
// Combinational lookup from an active-low segment pattern to {valid, nibble}.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  logic [4:0] dec;

  assign dec    = seg7_decode(seg);
  assign valid  = dec[4];
  assign nibble = dec[3:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed seven-segment bus, captures each digit after a stable
// hold, and presents the assembled multi-digit frame on a valid/ready port.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   out_value,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Handshake: a frame transfers on a rising edge where out_valid && out_ready;
  // out_value/out_err are stable from out_valid rising until that edge.

  localparam int              CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  state_t                state, state_nx;
  logic [6:0]            samp_seg;
  logic [DIGITS-1:0]     samp_en;
  logic [CW-1:0]         cnt;
  logic                  captured;
  logic [4*DIGITS-1:0]   slots, slots_nx;
  logic [DIGITS-1:0]     seen, seen_nx;
  logic [DIGITS-1:0]     bad, bad_merged, bad_nx;
  logic                  match, fire, load_out;
  logic [DIGITS-1:0]     cap_mask;
  logic                  dec_valid;
  logic [3:0]            dec_nib;

  seg7_pattern_decode u_decode (
    .seg    (samp_seg),
    .valid  (dec_valid),
    .nibble (dec_nib)
  );

  assign match    = $onehot(dig_en) && (seg == samp_seg) && (dig_en == samp_en);
  assign fire     = (cnt == CNT_MAX) && !captured;
  // cnt can only reach CNT_MAX with a one-hot sample, so samp_en is the slot select.
  assign cap_mask = fire ? samp_en : '0;

  always_comb begin
    slots_nx   = slots;
    bad_merged = bad;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap_mask[i]) begin
        slots_nx[4*i +: 4] = dec_valid ? dec_nib : 4'h0;
        bad_merged[i]      = ~dec_valid;
      end
    end
  end

  always_comb begin
    state_nx = state;
    seen_nx  = seen | cap_mask;
    bad_nx   = bad_merged;
    load_out = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (&seen) begin
          state_nx = ST_PRESENT;
          load_out = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          state_nx = ST_COLLECT;
          seen_nx  = cap_mask;
          bad_nx   = cap_mask & {DIGITS{~dec_valid}};
        end
      end
      default: state_nx = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_seg <= 7'h7F;
      samp_en  <= '0;
      cnt      <= '0;
      captured <= 1'b0;
    end else begin
      samp_seg <= seg;
      samp_en  <= dig_en;
      if (match) begin
        cnt      <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        captured <= captured | fire;
      end else begin
        cnt      <= '0;
        captured <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      slots     <= '0;
      seen      <= '0;
      bad       <= '0;
      out_value <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      slots     <= slots_nx;
      seen      <= seen_nx;
      bad       <= bad_nx;
      out_valid <= (state_nx == ST_PRESENT);
      if (load_out) begin
        out_value <= slots_nx;
        out_err   <= |bad_merged;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_decoder;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0010000, PA = 7'b0001000, PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110, PF = 7'b0001110;
  localparam logic [6:0] DASH = 7'b0111111, BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  dig_en = 4'b0000;
  logic [15:0] out_value;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          frame_cnt = 0;
  int          exp_cnt = 0;
  logic [16:0] last_frame = '0;
  logic [16:0] exp_q[$];

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .dig_en    (dig_en),
    .out_value (out_value),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      frame_cnt  <= frame_cnt + 1;
      last_frame <= {out_err, out_value};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] e, input int n);
    seg = s;
    dig_en = e;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input int h2);
    drive(p0, 4'b0001, 6);
    drive(p1, 4'b0010, 6);
    drive(p2, 4'b0100, h2);
    drive(p3, 4'b1000, 6);
  endtask

  task automatic expect_frame(input string name);
    logic [16:0] e;
    exp_cnt++;
    check({name, " count"}, 32'(frame_cnt), 32'(exp_cnt));
    e = exp_q.pop_front();
    check({name, " frame"}, 32'(last_frame), 32'(e));
  endtask

  task automatic expect_none(input string name);
    check({name, " count"}, 32'(frame_cnt), 32'(exp_cnt));
  endtask

  typedef struct {
    logic [6:0]  p0, p1, p2, p3;
    logic [15:0] val;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{P4,   P3,   P2, P1, 16'h1234, 1'b0};
    vecs[1] = '{P8,   P7,   P6, P5, 16'h5678, 1'b0};
    vecs[2] = '{PC,   PB,   PA, P9, 16'h9ABC, 1'b0};
    vecs[3] = '{P0,   PF,   PE, PD, 16'hDEF0, 1'b0};
    vecs[4] = '{P4,   DASH, P2, P1, 16'h1204, 1'b1};
    vecs[5] = '{BLANK, P3,  P2, P1, 16'h1230, 1'b1};
    vecs[6] = '{P4,   P3,   P2, P1, 16'h1234, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", 32'(out_valid), 32'(0));
    check("reset value", 32'(out_value), 32'(0));
    check("reset err", 32'(out_err), 32'(0));
    rst_n = 1'b1;
    drive(BLANK, 4'b0000, 2);

    // Table-driven full scans with ready held high
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({vecs[i].err, vecs[i].val});
      scan(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, 6);
      drive(BLANK, 4'b0000, 3);
      expect_frame($sformatf("vec%0d", i));
    end

    // Digit 2 held too short: no frame until a 4-sample hold
    scan(P4, P3, P2, P1, 3);
    scan(P4, P3, P2, P1, 3);
    expect_none("short hold");
    exp_q.push_back({1'b0, 16'h1234});
    drive(P2, 4'b0100, 4);
    drive(BLANK, 4'b0000, 4);
    expect_frame("min hold");

    // Backpressure: frame frozen while scan changes, exact frame latency
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h1234});
    drive(P4, 4'b0001, 6);
    drive(P3, 4'b0010, 6);
    drive(P2, 4'b0100, 6);
    drive(P1, 4'b1000, 5);
    check("valid before latency", 32'(out_valid), 32'(0));
    drive(P1, 4'b1000, 1);
    check("valid at latency", 32'(out_valid), 32'(1));
    check("value at latency", 32'(out_value), 32'h1234);
    scan(PF, PE, PD, PC, 6);
    check("frozen value", 32'(out_value), 32'h1234);
    check("frozen err", 32'(out_err), 32'(0));
    check("held valid", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    drive(BLANK, 4'b0000, 1);
    expect_frame("backpressure");
    check("valid after handshake", 32'(out_valid), 32'(0));
    exp_q.push_back({1'b0, 16'hCDEF});
    scan(PF, PE, PD, PC, 6);
    drive(BLANK, 4'b0000, 3);
    expect_frame("next frame");

    // Blanking / multi-hot enables never capture
    drive(P4, 4'b0001, 6);
    drive(P3, 4'b0010, 6);
    drive(P2, 4'b0100, 6);
    drive(P8, 4'b0011, 10);
    drive(P8, 4'b0000, 10);
    expect_none("blanking");
    exp_q.push_back({1'b0, 16'h1234});
    drive(P1, 4'b1000, 6);
    drive(BLANK, 4'b0000, 3);
    expect_frame("after blanking");

    // Reset mid-frame discards partial captures
    drive(P8, 4'b0001, 6);
    drive(P7, 4'b0010, 6);
    drive(P6, 4'b0100, 6);
    rst_n = 1'b0;
    #2;
    check("midrst valid", 32'(out_valid), 32'(0));
    check("midrst value", 32'(out_value), 32'(0));
    check("midrst err", 32'(out_err), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(P5, 4'b1000, 6);
    drive(BLANK, 4'b0000, 4);
    expect_none("post reset partial");
    exp_q.push_back({1'b0, 16'h5678});
    scan(P8, P7, P6, P5, 6);
    drive(BLANK, 4'b0000, 3);
    expect_frame("post reset full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
